bcd_addsub_seq: RTL and testbench

- Parametrised sequential 8421-BCD adder/subtractor for the arithmetic datapath.
- Processes DPC decimal digits per clock, least-significant digit group first, across a DIGITS-wide operand.
- Supports add and subtract (ten's-complement) with carry/borrow in and out, so instances chain for wider words.
- Uses a start/busy/done handshake, flags non-BCD input digits, and holds its result stable between operations.

---
 rtl/bcd_addsub_seq.sv | 180 ++++++++++++++++++
 tb/tb_bcd_addsub_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_seq.sv
// Sequential 8421-BCD adder/subtractor. Each RUN cycle consumes DPC digits
// from the low end of the operand shift registers and ripples them in one cycle.
module bcd_addsub_seq #(
    parameter int DIGITS = 8,
    parameter int DPC    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int GW = 4 * DPC;
    localparam int N  = DIGITS / DPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DIGITS < 1 || DPC < 1 || (DIGITS % DPC) != 0) begin : g_bad_params
            $error("bcd_addsub_seq: DIGITS must be >= 1 and divisible by DPC");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sub_q, sub_d;
    logic           c_q, c_d;
    logic           errw_q, errw_d;
    logic           cout_q, cout_d;
    logic           err_q, err_d;

    logic [W-1:0]    b_adj;
    logic            in_err;
    logic [GW-1:0]   grp_sum;
    logic            grp_cout;
    logic [W+GW-1:0] work_cat;
    logic [W-1:0]    work_next;

    // Subtraction runs as a + nines'-complement(b) + ~cin, so the carry chain
    // is shared with addition and the borrow is the inverted final carry.
    always_comb begin
        b_adj  = '0;
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            b_adj[4*i +: 4] = sub ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    always_comb begin : group_adder
        logic       c;
        logic [4:0] s;
        grp_sum = '0;
        c       = c_q;
        s       = '0;
        for (int j = 0; j < DPC; j++) begin
            s = {1'b0, a_q[4*j +: 4]} + {1'b0, b_q[4*j +: 4]} + {4'b0, c};
            if (s >= 5'd10) begin
                grp_sum[4*j +: 4] = s[3:0] + 4'd6;
                c = 1'b1;
            end else begin
                grp_sum[4*j +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        grp_cout = c;
    end

    // New digits enter at the top, so after N groups digit 0 sits at bits [3:0].
    assign work_cat  = {grp_sum, work_q};
    assign work_next = work_cat[W+GW-1:GW];

    // NOTE: every next-state signal is defaulted to its held value first so no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        c_d      = c_q;
        errw_d   = errw_q;
        cout_d   = cout_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_adj;
                    sub_d   = sub;
                    c_d     = sub ? ~cin : cin;
                    errw_d  = in_err;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d    = a_q >> GW;
                b_d    = b_q >> GW;
                c_d    = grp_cout;
                work_d = work_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = work_next;
                    cout_d   = sub_q ? ~grp_cout : grp_cout;
                    err_d    = errw_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values that were current before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            errw_q   <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            errw_q   <= errw_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign err    = err_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench: one DPC=1 and one DPC=4 instance, checked against an
// integer-arithmetic model of decimal add/subtract.
module tb_bcd_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4, sub, cin;
    logic [31:0] a, b;
    logic [31:0] res1, res4;
    logic        cout1, cout4, err1, err4, busy1, busy4, done1, done4;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_res [2];
    bit          last_valid [2];

    always #5 clk = ~clk;

    bcd_addsub_seq #(.DIGITS(8), .DPC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .result(res1), .cout(cout1), .err(err1), .busy(busy1), .done(done1)
    );

    bcd_addsub_seq #(.DIGITS(8), .DPC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
        .result(res4), .cout(cout4), .err(err4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint bcd2int(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint x);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [31:0] v);
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_bcd(input bit allow_bad);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0)
            r[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // Decimal reference: operate on the integer values, wrap modulo 10^8.
    task automatic model(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, output logic [31:0] r, output logic co);
        longint t;
        if (!s) begin
            t  = bcd2int(av) + bcd2int(bv) + longint'(ci);
            co = (t >= 100000000);
            t  = t % 100000000;
        end else begin
            t  = bcd2int(av) - bcd2int(bv) - longint'(ci);
            co = (t < 0);
            if (t < 0) t = t + 100000000;
        end
        r = int2bcd(t);
    endtask

    task automatic run_op(input bit wide, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input bit poke);
        int          n = wide ? 2 : 8;
        int          idx = wide ? 1 : 0;
        int          lat = 0, busy_cnt;
        bit          got_done = 0, hold_ok = 1, exp_err;
        logic [31:0] exp_res, r;
        logic        exp_cout;
        string       p = wide ? "dpc4" : "dpc1";

        model(s, av, bv, ci, exp_res, exp_cout);
        exp_err = has_bad(av) || has_bad(bv);

        @(negedge clk);
        a = av; b = bv; sub = s; cin = ci;
        if (wide) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!poke) begin start1 = 1'b0; start4 = 1'b0; end
        // Inputs change while the operation is in flight; it must not care.
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        busy_cnt = (wide ? busy4 : busy1) ? 1 : 0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (wide ? done4 : done1) got_done = 1;
            else begin
                if (wide ? busy4 : busy1) busy_cnt++;
                r = wide ? res4 : res1;
                if (last_valid[idx] && r !== last_res[idx]) hold_ok = 0;
            end
        end
        check({p, " latency"}, 32'(lat), 32'(n));
        check({p, " busy_cycles"}, 32'(busy_cnt), 32'(n));
        if (last_valid[idx]) check({p, " hold"}, 32'(hold_ok), 32'd1);
        check({p, " err"}, 32'(wide ? err4 : err1), 32'(exp_err));
        if (!exp_err) begin
            check({p, " result"}, wide ? res4 : res1, exp_res);
            check({p, " cout"}, 32'(wide ? cout4 : cout1), 32'(exp_cout));
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        check({p, " done_pulse"}, 32'(wide ? done4 : done1), 32'd0);
        check({p, " idle_busy"}, 32'(wide ? busy4 : busy1), 32'd0);
        last_res[idx]   = exp_res;
        last_valid[idx] = !exp_err;
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst result1", res1, 32'h0);
        check("rst flags1", {27'b0, cout1, err1, busy1, done1, 1'b0}, 32'h0);
        check("rst result4", res4, 32'h0);
        check("rst flags4", {27'b0, cout4, err4, busy4, done4, 1'b0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_res[0] = '0; last_res[1] = '0;
        last_valid[0] = 1; last_valid[1] = 1;

        run_op(0, 0, 32'h12345678, 32'h87654321, 0, 0);
        run_op(0, 0, 32'h99999999, 32'h00000001, 0, 0);
        run_op(0, 0, 32'h00000009, 32'h00000000, 1, 0);
        run_op(0, 1, 32'h00005000, 32'h00001234, 0, 0);
        run_op(0, 1, 32'h00000000, 32'h00000001, 0, 0);
        run_op(0, 1, 32'h00000010, 32'h00000009, 1, 0);
        run_op(0, 0, 32'h0000000A, 32'h00000001, 0, 0);
        run_op(0, 0, 32'h00000042, 32'h00000058, 0, 0);
        run_op(1, 0, 32'h11111111, 32'h22222222, 0, 1);
        run_op(1, 1, 32'h00000000, 32'h00000001, 1, 1);
        run_op(1, 0, 32'h99999999, 32'h99999999, 1, 0);

        for (int i = 0; i < 24; i++)
            run_op(i[0], 1'($urandom), rand_bcd(1), rand_bcd(1), 1'($urandom), i[1]);

        // Abort mid-operation: reset wins and no done follows.
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort result", res1, 32'h0);
        check("abort flags", {27'b0, cout1, err1, busy1, done1, 1'b0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done1) saw_done = 1;
        end
        check("abort no_done", 32'(saw_done), 32'd0);
        last_res[0] = '0; last_res[1] = '0;
        last_valid[0] = 1; last_valid[1] = 1;
        run_op(0, 0, 32'h12345678, 32'h11111111, 0, 0);
        run_op(0, 1, 32'h87654321, 32'h12345678, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
